// File: rtl/axi_rd_arbiter_if.sv
// Signal bundle for axi_rd_arbiter: icache refill port, core data-read port and AXI AR/R channels.
// master is the arbiter's view; slave is the view of the caches/interconnect around it.
interface axi_rd_arbiter_if;
    logic        ic_rd_req;
    logic [2:0]  ic_rd_type;
    logic [31:0] ic_rd_addr;
    logic        ic_rd_rdy;
    logic        ic_ret_valid;
    logic        ic_ret_last;
    logic [31:0] ic_ret_data;

    logic        d_req;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  ic_rd_req, ic_rd_type, ic_rd_addr,
        output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        input  d_req, d_size, d_addr,
        output d_addr_ok, d_data_ok, d_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready
    );

    modport slave (
        output ic_rd_req, ic_rd_type, ic_rd_addr,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        output d_req, d_size, d_addr,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// AXI read arbiter: icache refills vs. data reads, one AR at a time, R beats routed by rid.
// Define RD_ARB_RR_EN for round-robin arbitration; default is fixed data-first priority.
module axi_rd_arbiter #(
    parameter logic [3:0]  IC_ID      = 4'd0,
    parameter logic [3:0]  D_ID       = 4'd1,
    parameter int unsigned LINE_BEATS = 4
) (
    input logic              aclk,
    input logic              aresetn,
    axi_rd_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, AR_IC, AR_D} state_e;

    state_e      state_q, state_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        ic_busy_q, ic_busy_d;
    logic        d_busy_q, d_busy_d;
    logic        active_q;
    logic        grant_d, grant_ic;
    logic        d_elig, ic_elig, d_wins;
    logic        ic_beat, d_beat;
`ifdef RD_ARB_RR_EN
    logic        last_grant_q, last_grant_d;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_ic = 1'b0;
        // active_q keeps both grants low while reset is (or has just been) applied
        d_elig   = active_q & bus.d_req & ~d_busy_q;
        ic_elig  = active_q & bus.ic_rd_req & ~ic_busy_q;
`ifdef RD_ARB_RR_EN
        d_wins   = d_elig & (~ic_elig | ~last_grant_q);
`else
        d_wins   = d_elig;
`endif
        case (state_q)
            IDLE: begin
                grant_d  = d_wins;
                grant_ic = ic_elig & ~d_wins;
                if (grant_d)       state_d = AR_D;
                else if (grant_ic) state_d = AR_IC;
            end
            AR_IC, AR_D: if (bus.arready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.arvalid      = (state_q != IDLE);
        bus.d_addr_ok    = grant_d;
        bus.ic_rd_rdy    = grant_ic;
        bus.arid         = arid_q;
        bus.araddr       = araddr_q;
        bus.arlen        = arlen_q;
        bus.arsize       = arsize_q;
        bus.arburst      = 2'b01;
        bus.arlock       = '0;
        bus.arcache      = '0;
        bus.arprot       = '0;
        bus.rready       = active_q;
        ic_beat          = active_q & bus.rvalid & (bus.rid == IC_ID);
        d_beat           = active_q & bus.rvalid & (bus.rid == D_ID);
        bus.ic_ret_valid = ic_beat;
        bus.ic_ret_last  = (bus.rid == IC_ID) & bus.rlast;
        bus.ic_ret_data  = bus.rdata;
        bus.d_data_ok    = d_beat;
        bus.d_rdata      = bus.rdata;
    end

    always_comb begin
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        ic_busy_d = ic_busy_q;
        d_busy_d  = d_busy_q;
        if (ic_beat & bus.rlast) ic_busy_d = 1'b0;
        if (d_beat)              d_busy_d  = 1'b0;
        if (grant_d) begin
            arid_d   = D_ID;
            araddr_d = bus.d_addr;
            arlen_d  = '0;
            arsize_d = {1'b0, bus.d_size};
            d_busy_d = 1'b1;
        end else if (grant_ic) begin
            arid_d    = IC_ID;
            araddr_d  = bus.ic_rd_addr;
            arlen_d   = bus.ic_rd_type[2] ? 8'(LINE_BEATS - 1) : '0;
            arsize_d  = bus.ic_rd_type[2] ? 3'b010 : {1'b0, bus.ic_rd_type[1:0]};
            ic_busy_d = 1'b1;
        end
`ifdef RD_ARB_RR_EN
        last_grant_d = grant_d ? 1'b1 : (grant_ic ? 1'b0 : last_grant_q);
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            ic_busy_q <= 1'b0;
            d_busy_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            ic_busy_q <= ic_busy_d;
            d_busy_q  <= d_busy_d;
            active_q  <= 1'b1;
        end
    end

`ifdef RD_ARB_RR_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) last_grant_q <= 1'b0;
        else          last_grant_q <= last_grant_d;
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR transactions and returned beats are queued
// when stimulus is driven and checked by a monitor when the arbiter presents them.
module tb_axi_rd_arbiter;

    localparam logic [3:0] IC  = 4'd0;
    localparam logic [3:0] DID = 4'd1;

    logic aclk = 1'b0;
    logic aresetn;
    int   checks = 0;
    int   errors = 0;

    logic [46:0] ar_exp[$];
    logic [32:0] ic_exp[$];
    logic [31:0] d_exp[$];

    axi_rd_arbiter_if ifc();

    axi_rd_arbiter #(.IC_ID(4'd0), .D_ID(4'd1), .LINE_BEATS(4)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(ifc)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin : monitor
        logic [46:0] ar_e;
        logic [32:0] ic_e;
        logic [31:0] d_e;
        if (aresetn) begin
            if (ifc.arvalid && ifc.arready) begin
                checks++;
                if (ar_exp.size() == 0) begin
                    errors++;
                    $display("FAIL ar_unexpected got %h want none", {ifc.arid, ifc.araddr, ifc.arlen, ifc.arsize});
                end else begin
                    ar_e = ar_exp.pop_front();
                    if ({ifc.arid, ifc.araddr, ifc.arlen, ifc.arsize} !== ar_e) begin
                        errors++;
                        $display("FAIL ar_fields got %h want %h", {ifc.arid, ifc.araddr, ifc.arlen, ifc.arsize}, ar_e);
                    end
                end
            end
            if (ifc.ic_ret_valid) begin
                checks++;
                if (ic_exp.size() == 0) begin
                    errors++;
                    $display("FAIL ic_unexpected got %h want none", {ifc.ic_ret_last, ifc.ic_ret_data});
                end else begin
                    ic_e = ic_exp.pop_front();
                    if ({ifc.ic_ret_last, ifc.ic_ret_data} !== ic_e) begin
                        errors++;
                        $display("FAIL ic_beat got %h want %h", {ifc.ic_ret_last, ifc.ic_ret_data}, ic_e);
                    end
                end
            end
            if (ifc.d_data_ok) begin
                checks++;
                if (d_exp.size() == 0) begin
                    errors++;
                    $display("FAIL d_unexpected got %h want none", ifc.d_rdata);
                end else begin
                    d_e = d_exp.pop_front();
                    if (ifc.d_rdata !== d_e) begin
                        errors++;
                        $display("FAIL d_beat got %h want %h", ifc.d_rdata, d_e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic last);
        ifc.rid    = id;
        ifc.rdata  = data;
        ifc.rlast  = last;
        ifc.rvalid = 1'b1;
        tick();
        ifc.rvalid = 1'b0;
        ifc.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        ifc.rvalid = 1'b1; ifc.rid = IC; ifc.rlast = 1'b1; ifc.rdata = 32'h12345678;
        ifc.d_req = 1'b1; ifc.ic_rd_req = 1'b1; ifc.arready = 1'b1;
        #12;
        checks++;
        if ({ifc.arvalid, ifc.ic_rd_rdy, ifc.d_addr_ok, ifc.ic_ret_valid, ifc.d_data_ok} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {ifc.arvalid, ifc.ic_rd_rdy, ifc.d_addr_ok, ifc.ic_ret_valid, ifc.d_data_ok});
        end
        checks++;
        if ({ifc.arid, ifc.araddr, ifc.arlen, ifc.arsize} !== 47'h0) begin
            errors++;
            $display("FAIL reset_ar got %h want 0", {ifc.arid, ifc.araddr, ifc.arlen, ifc.arsize});
        end
        checks++;
        if ({ifc.arburst, ifc.arlock, ifc.arcache, ifc.arprot} !== 11'b01_00_0000_000) begin
            errors++;
            $display("FAIL ar_const got %b want 01000000000", {ifc.arburst, ifc.arlock, ifc.arcache, ifc.arprot});
        end
        ifc.rvalid = 1'b0; ifc.rlast = 1'b0; ifc.d_req = 1'b0; ifc.ic_rd_req = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        @(negedge aclk);
        checks++;
        if ({ifc.rready, ifc.arvalid} !== 2'b10) begin
            errors++;
            $display("FAIL rready_after_reset got %b want 10", {ifc.rready, ifc.arvalid});
        end
        tick();
    endtask

    task automatic test_line_refill();
        ifc.arready = 1'b1;
        ifc.ic_rd_req = 1'b1; ifc.ic_rd_type = 3'b100; ifc.ic_rd_addr = 32'h1c000040;
        @(negedge aclk);
        checks++;
        if (ifc.ic_rd_rdy !== 1'b1) begin errors++; $display("FAIL line_rdy got %b want 1", ifc.ic_rd_rdy); end
        ar_exp.push_back({IC, 32'h1c000040, 8'd3, 3'd2});
        tick();
        ifc.ic_rd_req = 1'b0;
        @(negedge aclk);
        checks++;
        if ({ifc.arvalid, ifc.ic_rd_rdy} !== 2'b10) begin
            errors++; $display("FAIL line_arvalid got %b want 10", {ifc.arvalid, ifc.ic_rd_rdy});
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            ic_exp.push_back({logic'(i == 3), 32'hA0 + 32'(i)});
            r_beat(IC, 32'hA0 + 32'(i), logic'(i == 3));
        end
    endtask

    task automatic test_ic_word();
        ifc.ic_rd_req = 1'b1; ifc.ic_rd_type = 3'b001; ifc.ic_rd_addr = 32'h1c000102;
        @(negedge aclk);
        checks++;
        if (ifc.ic_rd_rdy !== 1'b1) begin errors++; $display("FAIL half_rdy got %b want 1", ifc.ic_rd_rdy); end
        ar_exp.push_back({IC, 32'h1c000102, 8'd0, 3'd1});
        tick();
        ifc.ic_rd_req = 1'b0;
        tick();
        ic_exp.push_back({1'b1, 32'h0000BEEF});
        r_beat(IC, 32'h0000BEEF, 1'b1);
    endtask

    task automatic test_data_read();
        ifc.d_req = 1'b1; ifc.d_size = 2'd0; ifc.d_addr = 32'h800;
        @(negedge aclk);
        checks++;
        if ({ifc.d_addr_ok, ifc.ic_rd_rdy} !== 2'b10) begin
            errors++; $display("FAIL data_addr_ok got %b want 10", {ifc.d_addr_ok, ifc.ic_rd_rdy});
        end
        ar_exp.push_back({DID, 32'h800, 8'd0, 3'd0});
        tick();
        ifc.d_req = 1'b0;
        tick();
        d_exp.push_back(32'h55);
        r_beat(DID, 32'h55, 1'b1);
        @(negedge aclk);
        checks++;
        if (ifc.d_data_ok !== 1'b0) begin errors++; $display("FAIL data_ok_pulse got %b want 0", ifc.d_data_ok); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic first_d;
`ifdef RD_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        ifc.arready = 1'b1;
        ifc.d_req = 1'b1; ifc.d_size = 2'd2; ifc.d_addr = 32'h900;
        ifc.ic_rd_req = 1'b1; ifc.ic_rd_type = 3'b010; ifc.ic_rd_addr = 32'h1c000200;
        @(negedge aclk);
        checks++;
        if ({ifc.d_addr_ok, ifc.ic_rd_rdy} !== (first_d ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL sim_first got %b want %b", {ifc.d_addr_ok, ifc.ic_rd_rdy}, first_d ? 2'b10 : 2'b01);
        end
        if (first_d) ar_exp.push_back({DID, 32'h900, 8'd0, 3'd2});
        else         ar_exp.push_back({IC, 32'h1c000200, 8'd0, 3'd2});
        tick();
        if (first_d) ifc.d_req = 1'b0; else ifc.ic_rd_req = 1'b0;
        @(negedge aclk);
        checks++;
        if ({ifc.d_addr_ok, ifc.ic_rd_rdy} !== 2'b00) begin
            errors++; $display("FAIL sim_hold got %b want 00", {ifc.d_addr_ok, ifc.ic_rd_rdy});
        end
        tick();
        @(negedge aclk);
        checks++;
        if ({ifc.d_addr_ok, ifc.ic_rd_rdy} !== (first_d ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL sim_second got %b want %b", {ifc.d_addr_ok, ifc.ic_rd_rdy}, first_d ? 2'b01 : 2'b10);
        end
        if (first_d) ar_exp.push_back({IC, 32'h1c000200, 8'd0, 3'd2});
        else         ar_exp.push_back({DID, 32'h900, 8'd0, 3'd2});
        tick();
        ifc.d_req = 1'b0; ifc.ic_rd_req = 1'b0;
        tick();
        d_exp.push_back(32'h1111);
        r_beat(DID, 32'h1111, 1'b1);
        ic_exp.push_back({1'b1, 32'h2222});
        r_beat(IC, 32'h2222, 1'b1);
    endtask

    task automatic test_interleaved();
        ifc.ic_rd_req = 1'b1; ifc.ic_rd_type = 3'b100; ifc.ic_rd_addr = 32'h1c000300;
        @(negedge aclk);
        ar_exp.push_back({IC, 32'h1c000300, 8'd3, 3'd2});
        tick();
        ifc.ic_rd_req = 1'b0;
        tick();
        ifc.d_req = 1'b1; ifc.d_size = 2'd1; ifc.d_addr = 32'h904;
        @(negedge aclk);
        checks++;
        if (ifc.d_addr_ok !== 1'b1) begin errors++; $display("FAIL d_while_ic_busy got %b want 1", ifc.d_addr_ok); end
        ar_exp.push_back({DID, 32'h904, 8'd0, 3'd1});
        tick();
        ifc.d_req = 1'b0;
        tick();
        ic_exp.push_back({1'b0, 32'hB0}); r_beat(IC, 32'hB0, 1'b0);
        ic_exp.push_back({1'b0, 32'hB1}); r_beat(IC, 32'hB1, 1'b0);
        d_exp.push_back(32'h77);          r_beat(DID, 32'h77, 1'b1);
        ifc.rid = 4'd7; ifc.rdata = 32'hDEAD; ifc.rlast = 1'b1; ifc.rvalid = 1'b1;
        @(negedge aclk);
        checks++;
        if ({ifc.ic_ret_valid, ifc.d_data_ok, ifc.rready} !== 3'b001) begin
            errors++; $display("FAIL foreign_beat got %b want 001", {ifc.ic_ret_valid, ifc.d_data_ok, ifc.rready});
        end
        tick();
        ifc.rvalid = 1'b0; ifc.rlast = 1'b0;
        ic_exp.push_back({1'b0, 32'hB2}); r_beat(IC, 32'hB2, 1'b0);
        ic_exp.push_back({1'b1, 32'hB3}); r_beat(IC, 32'hB3, 1'b1);
    endtask

    task automatic test_backpressure();
        ifc.arready = 1'b0;
        ifc.d_req = 1'b1; ifc.d_size = 2'd2; ifc.d_addr = 32'h1234;
        @(negedge aclk);
        checks++;
        if (ifc.d_addr_ok !== 1'b1) begin errors++; $display("FAIL bp_grant got %b want 1", ifc.d_addr_ok); end
        ar_exp.push_back({DID, 32'h1234, 8'd0, 3'd2});
        tick();
        ifc.d_req = 1'b0;
        ifc.ic_rd_req = 1'b1; ifc.ic_rd_type = 3'b000; ifc.ic_rd_addr = 32'h1c000401;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if ({ifc.arvalid, ifc.arid, ifc.araddr, ifc.arlen, ifc.arsize} !== {1'b1, DID, 32'h1234, 8'd0, 3'd2}) begin
                errors++;
                $display("FAIL bp_hold got %h want %h", {ifc.arvalid, ifc.arid, ifc.araddr, ifc.arlen, ifc.arsize},
                         {1'b1, DID, 32'h1234, 8'd0, 3'd2});
            end
            checks++;
            if ({ifc.ic_rd_rdy, ifc.d_addr_ok} !== 2'b00) begin
                errors++; $display("FAIL bp_nogrant got %b want 00", {ifc.ic_rd_rdy, ifc.d_addr_ok});
            end
            tick();
        end
        ifc.arready = 1'b1;
        tick();
        @(negedge aclk);
        checks++;
        if (ifc.ic_rd_rdy !== 1'b1) begin errors++; $display("FAIL bp_next_grant got %b want 1", ifc.ic_rd_rdy); end
        ar_exp.push_back({IC, 32'h1c000401, 8'd0, 3'd0});
        tick();
        ifc.ic_rd_req = 1'b0;
        tick();
        d_exp.push_back(32'h3333);        r_beat(DID, 32'h3333, 1'b1);
        ic_exp.push_back({1'b1, 32'h44}); r_beat(IC, 32'h44, 1'b1);
    endtask

    task automatic test_back_to_back();
        ifc.arready = 1'b1;
        ifc.ic_rd_req = 1'b1; ifc.ic_rd_type = 3'b100; ifc.ic_rd_addr = 32'h1c000500;
        @(negedge aclk);
        ar_exp.push_back({IC, 32'h1c000500, 8'd3, 3'd2});
        tick();
        ifc.ic_rd_type = 3'b010; ifc.ic_rd_addr = 32'h1c000540;
        tick();
        for (int i = 0; i < 4; i++) begin
            ic_exp.push_back({logic'(i == 3), 32'hC0 + 32'(i)});
            ifc.rid = IC; ifc.rdata = 32'hC0 + 32'(i); ifc.rlast = logic'(i == 3); ifc.rvalid = 1'b1;
            @(negedge aclk);
            checks++;
            if (ifc.ic_rd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", ifc.ic_rd_rdy); end
            tick();
        end
        ifc.rvalid = 1'b0; ifc.rlast = 1'b0;
        @(negedge aclk);
        checks++;
        if (ifc.ic_rd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_regrant got %b want 1", ifc.ic_rd_rdy); end
        ar_exp.push_back({IC, 32'h1c000540, 8'd0, 3'd2});
        tick();
        ifc.ic_rd_req = 1'b0;
        tick();
        ic_exp.push_back({1'b1, 32'h600D}); r_beat(IC, 32'h600D, 1'b1);
    endtask

    task automatic test_reset_mid();
        ifc.arready = 1'b0;
        ifc.ic_rd_req = 1'b1; ifc.ic_rd_type = 3'b100; ifc.ic_rd_addr = 32'h1c000700;
        tick();
        ifc.ic_rd_req = 1'b0;
        @(negedge aclk);
        checks++;
        if (ifc.arvalid !== 1'b1) begin errors++; $display("FAIL rst_pre got %b want 1", ifc.arvalid); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (ifc.arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b want 0", ifc.arvalid); end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        ifc.arready = 1'b1;
        tick();
        ifc.d_req = 1'b1; ifc.d_size = 2'd2; ifc.d_addr = 32'hA00;
        @(negedge aclk);
        checks++;
        if (ifc.d_addr_ok !== 1'b1) begin errors++; $display("FAIL rst_regrant got %b want 1", ifc.d_addr_ok); end
        ar_exp.push_back({DID, 32'hA00, 8'd0, 3'd2});
        tick();
        ifc.d_req = 1'b0;
        tick();
        d_exp.push_back(32'h99); r_beat(DID, 32'h99, 1'b1);
    endtask

    task automatic test_drain();
        repeat (3) tick();
        checks++;
        if (ar_exp.size() != 0) begin errors++; $display("FAIL ar_pending got %0d want 0", ar_exp.size()); end
        checks++;
        if (ic_exp.size() != 0) begin errors++; $display("FAIL ic_pending got %0d want 0", ic_exp.size()); end
        checks++;
        if (d_exp.size() != 0) begin errors++; $display("FAIL d_pending got %0d want 0", d_exp.size()); end
    endtask

    initial begin
        aresetn = 1'b0;
        ifc.ic_rd_req = 1'b0; ifc.ic_rd_type = 3'b000; ifc.ic_rd_addr = '0;
        ifc.d_req = 1'b0; ifc.d_size = 2'd0; ifc.d_addr = '0;
        ifc.arready = 1'b0;
        ifc.rid = '0; ifc.rdata = '0; ifc.rlast = 1'b0; ifc.rvalid = 1'b0;
        test_reset();
        test_line_refill();
        test_ic_word();
        test_data_read();
        test_simultaneous();
        test_interleaved();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Read-side AXI master stage between the instruction cache refill port / core data-read port and the AXI AR/R channels of the top level. It arbitrates icache line refills (4-beat INCR burst) against single-beat data reads. It issues one AR transaction at a time and routes R beats back to the owner by rid. The data write path is outside this block; the parent holds data_req low while a write to the same address is pending.

Parameters:
IC_ID, 4'd0, arid used for icache refills
D_ID, 4'd1, arid used for data reads
LINE_BEATS, 4, beats per icache line (arlen = LINE_BEATS-1)

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
ic_rd_req  in  1  icache refill request
ic_rd_type  in  3  3'b100 = line, 3'b010 = word, 3'b001 = half, 3'b000 = byte
ic_rd_addr  in  32  refill physical address
ic_rd_rdy  out  1  request accepted this cycle when ic_rd_req=1
ic_ret_valid  out  1  refill beat valid
ic_ret_last  out  1  last refill beat
ic_ret_data  out  32  refill beat data
d_req  in  1  data read request
d_size  in  2  0 = byte, 1 = half, 2 = word
d_addr  in  32  data physical address
d_addr_ok  out  1  data request accepted
d_data_ok  out  1  data read returned
d_rdata  out  32  data read value
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI AR channel
arready  in  1  AXI AR handshake
rid/rdata/rlast/rvalid  in  4/32/1/1  AXI R channel
rready  out  1  AXI R accept

Behaviour:
- Clock and reset: single clock aclk; reset aresetn is asynchronous, active-low.
- Reset values: arvalid=0, araddr=0, arid=0, arlen=0, arsize=0, ic_rd_rdy=0, d_addr_ok=0, ic_ret_valid=0, d_data_ok=0, ic_busy=0, d_busy=0, state=IDLE. rready=1 from the first cycle after reset.
- Constant outputs: arburst=2'b01, arlock=0, arcache=0, arprot=0.

AR state machine (IDLE, AR_IC, AR_D):
- IDLE:
  - grant_d = d_req & !d_busy.
  - grant_ic = ic_rd_req & !ic_busy & !grant_d (fixed priority: data first).
  - d_addr_ok = grant_d and ic_rd_rdy = grant_ic, both combinational and asserted only in IDLE.
- On grant, latch the request; arvalid=1 from the next cycle.
  - Data grant: arid=D_ID, araddr=d_addr, arlen=0, arsize={1'b0,d_size}; set d_busy; go to AR_D.
  - Icache grant: arid=IC_ID, araddr=ic_rd_addr; for a line, arlen=LINE_BEATS-1 and arsize=3'b010; otherwise arlen=0 and arsize={1'b0,ic_rd_type[1:0]}. Set ic_busy; go to AR_IC.
- AR_IC / AR_D: hold arvalid and all AR fields stable until arvalid & arready, then return to IDLE with arvalid=0. No grant while not in IDLE.
- Minimum spacing: the earliest next grant is the cycle after the AR handshake. One outstanding transaction per source; at most two in flight in total.

R routing (combinational):
- rid==IC_ID:
  - ic_ret_valid=rvalid, ic_ret_last=rlast, ic_ret_data=rdata.
  - ic_busy clears at the clock edge where rvalid & rlast.
- rid==D_ID:
  - d_data_ok=rvalid, d_rdata=rdata.
  - d_busy clears at the clock edge where rvalid.
- Any other rid: beat is consumed and dropped; no output pulses.
- Interleaving: beats of the two sources may interleave arbitrarily; routing is per beat.

Boundary conditions:
- Busy clear and new grant: busy flags are registered, so a completion in cycle N permits a new grant from the same source at cycle N+1 at the earliest.
- Source request while its busy flag is set: it is stalled and the other source may be granted.
- Both sources requesting in IDLE: data is granted. If the icache keeps requesting, it is granted in the next IDLE cycle once d_busy is set.
- Reset mid-operation: arvalid drops immediately. Busy flags clear and in-flight responses are discarded; the environment is reset together with this block.

Optional Feature:
RD_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last_grant register (reset 0 = icache) gives priority to the source not granted last, when both request in the same IDLE cycle.
- Undefined: fixed data-first priority as above.

Test Plan:
- Line refill: ic_rd_req, type 3'b100, addr 0x1c000040; arready=1 -> one cycle with ic_rd_rdy=1, then arvalid with arid=0, arlen=3, arsize=2; 4 R beats 0xA0..0xA3 -> ic_ret_valid on 4 cycles, ic_ret_last only on the 4th.
- Data byte read: d_req, d_size=0, d_addr=0x800 -> arlen=0, arsize=0, arid=1; R beat rdata=0x55 -> d_data_ok for 1 cycle, d_rdata=0x55.
- Simultaneous requests: both requests in the same cycle -> d_addr_ok first; ic_rd_rdy exactly one cycle after the data AR handshake. With RD_ARB_RR_EN and last grant = data, the icache wins instead.
- Interleaved R: icache burst in flight, a D_ID beat arrives between IC beats 1 and 2 -> d_data_ok pulses once; icache beat count unaffected.
- Backpressure: arready=0 for 5 cycles -> arvalid and all AR fields held constant; no new grant issued.
- Async reset asserted while AR_IC has arvalid=1 -> arvalid low the same cycle; after release, a new d_req is granted normally.
